// File: rtl/host_dma_cmd_issuer.sv
// rtl/host_dma_cmd_issuer.sv - DMA command issuer with ID pool, response matching and completion FIFO
module host_dma_cmd_issuer #(
  parameter int NumIds     = 8,
  parameter int IdWidth    = $clog2(NumIds),
  parameter int CmdIdWidth = 8,
  parameter int TagWidth   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_nic_to_host_i,
  input  logic [63:0]           req_host_addr_i,
  input  logic [31:0]           req_nic_addr_i,
  input  logic [31:0]           req_length_i,
  input  logic [TagWidth-1:0]   req_tag_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [CmdIdWidth-1:0] cmd_id_o,
  output logic                  cmd_nic_to_host_o,
  output logic [63:0]           cmd_host_addr_o,
  output logic [31:0]           cmd_nic_addr_o,
  output logic [31:0]           cmd_length_o,
  input  logic                  cmd_resp_valid_i,
  input  logic [CmdIdWidth-1:0] cmd_resp_id_i,
  output logic                  cpl_valid_o,
  input  logic                  cpl_ready_i,
  output logic [TagWidth-1:0]   cpl_tag_o,
  output logic                  cpl_nic_to_host_o,
  output logic [IdWidth:0]      inflight_o,
  output logic                  err_o
);

  // ID bookkeeping: busy = allocated, pending = response seen but not yet popped
  logic [NumIds-1:0]   busy_q, pending_q, busy_d, pending_d;
  logic [TagWidth-1:0] tag_tbl_q [NumIds];
  logic [NumIds-1:0]   dir_tbl_q;

  // completion FIFO of IDs in response-arrival order
  logic [IdWidth-1:0]  fifo_q [NumIds];
  logic [IdWidth-1:0]  rd_ptr_q, wr_ptr_q;
  logic [IdWidth:0]    count_q;

  // command output register
  logic                cmd_valid_q;
  logic [IdWidth-1:0]  cmd_id_q;

  logic                any_free;
  logic [IdWidth-1:0]  alloc_id;
  logic                accept, push, pop, resp_in_range;
  logic [IdWidth-1:0]  resp_idx, head_id;
  logic [IdWidth:0]    inflight_cnt;

  // priority pick of the lowest-index free ID
  always_comb begin
    any_free = 1'b0;
    alloc_id = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        alloc_id = IdWidth'(i);
      end
    end
  end

  assign req_ready_o = rst_ni & any_free & (~cmd_valid_q | cmd_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  // IDs wider than the pool index are out of range when any upper bit is set
  if (CmdIdWidth > IdWidth) begin : g_range
    assign resp_in_range = ~|cmd_resp_id_i[CmdIdWidth-1:IdWidth];
  end else begin : g_norange
    assign resp_in_range = 1'b1;
  end

  assign resp_idx = cmd_resp_id_i[IdWidth-1:0];
  // a response for an ID popped this same cycle still sees pending set and is rejected
  assign push     = cmd_resp_valid_i & resp_in_range & busy_q[resp_idx] & ~pending_q[resp_idx];
  assign head_id  = fifo_q[rd_ptr_q];
  assign pop      = cpl_valid_o & cpl_ready_i;

  assign cpl_valid_o       = (count_q != '0);
  assign cpl_tag_o         = tag_tbl_q[head_id];
  assign cpl_nic_to_host_o = dir_tbl_q[head_id];

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_id_o    = CmdIdWidth'(cmd_id_q);

  // next-state of busy/pending; pop and accept never touch the same ID
  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    if (pop) begin
      busy_d[head_id]    = 1'b0;
      pending_d[head_id] = 1'b0;
    end
    if (push) pending_d[resp_idx] = 1'b1;
    if (accept) busy_d[alloc_id] = 1'b1;
  end

  // number of allocated IDs
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < NumIds; i++) begin
      inflight_cnt = inflight_cnt + {{IdWidth{1'b0}}, busy_q[i]};
    end
  end
  assign inflight_o = inflight_cnt;

  // control state, command register and FIFO pointers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_q            <= '0;
      pending_q         <= '0;
      cmd_valid_q       <= 1'b0;
      cmd_id_q          <= '0;
      cmd_nic_to_host_o <= 1'b0;
      cmd_host_addr_o   <= '0;
      cmd_nic_addr_o    <= '0;
      cmd_length_o      <= '0;
      rd_ptr_q          <= '0;
      wr_ptr_q          <= '0;
      count_q           <= '0;
      err_o             <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      if (accept) begin
        cmd_valid_q       <= 1'b1;
        cmd_id_q          <= alloc_id;
        cmd_nic_to_host_o <= req_nic_to_host_i;
        cmd_host_addr_o   <= req_host_addr_i;
        cmd_nic_addr_o    <= req_nic_addr_i;
        cmd_length_o      <= req_length_i;
      end else if (cmd_ready_i) begin
        cmd_valid_q <= 1'b0;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{IdWidth{1'b0}}, push} - {{IdWidth{1'b0}}, pop};
      if (cmd_resp_valid_i && !push) err_o <= 1'b1;
    end
  end

  // per-ID request table and FIFO storage need no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      tag_tbl_q[alloc_id] <= req_tag_i;
      dir_tbl_q[alloc_id] <= req_nic_to_host_i;
    end
    if (push) fifo_q[wr_ptr_q] <= resp_idx;
  end

  // the FIFO is as deep as the ID pool, so a push can never find it full
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) assert (count_q != (IdWidth + 1)'(NumIds));
  end

endmodule

// File: tb/tb_host_dma_cmd_issuer.sv
// tb/tb_host_dma_cmd_issuer.sv - directed self-checking bench for host_dma_cmd_issuer
module tb_host_dma_cmd_issuer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_nic_to_host_i;
  logic [63:0] req_host_addr_i;
  logic [31:0] req_nic_addr_i;
  logic [31:0] req_length_i;
  logic [3:0]  req_tag_i;
  logic        cmd_valid_o;
  logic        cmd_ready_i;
  logic [7:0]  cmd_id_o;
  logic        cmd_nic_to_host_o;
  logic [63:0] cmd_host_addr_o;
  logic [31:0] cmd_nic_addr_o;
  logic [31:0] cmd_length_o;
  logic        cmd_resp_valid_i;
  logic [7:0]  cmd_resp_id_i;
  logic        cpl_valid_o;
  logic        cpl_ready_i;
  logic [3:0]  cpl_tag_o;
  logic        cpl_nic_to_host_o;
  logic [3:0]  inflight_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  host_dma_cmd_issuer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_nic_to_host_i(req_nic_to_host_i), .req_host_addr_i(req_host_addr_i),
    .req_nic_addr_i(req_nic_addr_i), .req_length_i(req_length_i), .req_tag_i(req_tag_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_id_o(cmd_id_o),
    .cmd_nic_to_host_o(cmd_nic_to_host_o), .cmd_host_addr_o(cmd_host_addr_o),
    .cmd_nic_addr_o(cmd_nic_addr_o), .cmd_length_o(cmd_length_o),
    .cmd_resp_valid_i(cmd_resp_valid_i), .cmd_resp_id_i(cmd_resp_id_i),
    .cpl_valid_o(cpl_valid_o), .cpl_ready_i(cpl_ready_i), .cpl_tag_o(cpl_tag_o),
    .cpl_nic_to_host_o(cpl_nic_to_host_o), .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic dir, input logic [63:0] ha,
                         input logic [31:0] na, input logic [31:0] len, input logic [3:0] tag);
    req_valid_i       = v;
    req_nic_to_host_i = dir;
    req_host_addr_i   = ha;
    req_nic_addr_i    = na;
    req_length_i      = len;
    req_tag_i         = tag;
  endtask

  task automatic resp(input logic [7:0] id);
    cmd_resp_valid_i = 1'b1;
    cmd_resp_id_i    = id;
    tick();
    cmd_resp_valid_i = 1'b0;
    settle();
  endtask

  initial begin
    rst_ni = 1'b0;
    set_req(1'b0, 1'b0, 64'h0, 32'h0, 32'h0, 4'h0);
    cmd_ready_i      = 1'b0;
    cmd_resp_valid_i = 1'b0;
    cmd_resp_id_i    = 8'h0;
    cpl_ready_i      = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_cpl_valid", cpl_valid_o, 0);
    chk("rst_inflight", inflight_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    settle();

    // single request
    set_req(1'b1, 1'b1, 64'h1_0000_1000, 32'h0000_0040, 32'd256, 4'd3);
    settle();
    chk("single_req_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    settle();
    chk("single_cmd_valid", cmd_valid_o, 1);
    chk("single_cmd_id", cmd_id_o, 0);
    chk("single_dir", cmd_nic_to_host_o, 1);
    chk("single_haddr", cmd_host_addr_o, 64'h1_0000_1000);
    chk("single_naddr", cmd_nic_addr_o, 32'h40);
    chk("single_len", cmd_length_o, 256);
    chk("single_inflight1", inflight_o, 1);
    cmd_ready_i = 1'b1;
    tick();
    chk("single_cmd_drop", cmd_valid_o, 0);
    resp(8'd0);
    chk("single_cpl_valid", cpl_valid_o, 1);
    chk("single_cpl_tag", cpl_tag_o, 3);
    chk("single_cpl_dir", cpl_nic_to_host_o, 1);
    chk("single_inflight_hold", inflight_o, 1);
    cpl_ready_i = 1'b1;
    tick();
    cpl_ready_i = 1'b0;
    settle();
    chk("single_cpl_done", cpl_valid_o, 0);
    chk("single_inflight0", inflight_o, 0);

    // fill the pool: tags equal IDs, dir = bit 1 of the ID
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, i[1], 64'h2000 + 64'(i), 32'(i), 32'd64, 4'(i));
      tick();
      chk("fill_cmd_id", cmd_id_o, 64'(i));
      chk("fill_cmd_valid", cmd_valid_o, 1);
    end
    set_req(1'b1, 1'b1, 64'h9999, 32'h9, 32'd8, 4'd9);
    settle();
    chk("full_req_ready", req_ready_o, 0);
    chk("full_inflight", inflight_o, 8);
    resp(8'd5);
    chk("pop5_cpl_tag", cpl_tag_o, 5);
    cpl_ready_i = 1'b1;
    settle();
    chk("pop5_same_cycle_ready", req_ready_o, 0);
    tick();
    cpl_ready_i = 1'b0;
    settle();
    chk("pop5_next_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    settle();
    chk("ninth_cmd_id", cmd_id_o, 5);
    chk("ninth_haddr", cmd_host_addr_o, 64'h9999);
    chk("ninth_inflight", inflight_o, 8);
    tick();

    // out-of-order responses with a stalled completion consumer
    resp(8'd6);
    resp(8'd2);
    resp(8'd0);
    for (int i = 0; i < 10; i++) tick();
    chk("ooo_cpl_valid", cpl_valid_o, 1);
    cpl_ready_i = 1'b1;
    settle();
    chk("ooo_tag0", cpl_tag_o, 6);
    chk("ooo_dir0", cpl_nic_to_host_o, 1);
    tick();
    chk("ooo_tag1", cpl_tag_o, 2);
    tick();
    chk("ooo_tag2", cpl_tag_o, 0);
    chk("ooo_dir2", cpl_nic_to_host_o, 0);
    tick();
    cpl_ready_i = 1'b0;
    settle();
    chk("ooo_empty", cpl_valid_o, 0);
    chk("ooo_inflight", inflight_o, 5);
    chk("ooo_no_err", err_o, 0);

    // command back-pressure: free IDs are 0, 2, 6
    cmd_ready_i = 1'b0;
    set_req(1'b1, 1'b0, 64'hAAAA_0000, 32'hA, 32'd0, 4'hA);
    tick();
    set_req(1'b1, 1'b1, 64'hBBBB_0000, 32'hB, 32'd16, 4'hB);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("stall_req_ready", req_ready_o, 0);
      chk("stall_cmd_id", cmd_id_o, 0);
      chk("stall_haddr", cmd_host_addr_o, 64'hAAAA_0000);
      chk("stall_len", cmd_length_o, 0);
      tick();
    end
    cmd_ready_i = 1'b1;
    settle();
    chk("stall_release_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    settle();
    chk("stall_next_id", cmd_id_o, 2);
    chk("stall_next_haddr", cmd_host_addr_o, 64'hBBBB_0000);
    tick();
    chk("stall_drain", cmd_valid_o, 0);
    chk("stall_inflight", inflight_o, 7);

    // spurious responses: out of range, unallocated, duplicate
    resp(8'd9);
    chk("spur9_err", err_o, 1);
    chk("spur9_no_cpl", cpl_valid_o, 0);
    chk("spur9_inflight", inflight_o, 7);
    resp(8'd6);
    chk("spur6_no_cpl", cpl_valid_o, 0);
    chk("spur6_inflight", inflight_o, 7);
    resp(8'd4);
    resp(8'd4);
    chk("dup_tag", cpl_tag_o, 4);
    cpl_ready_i = 1'b1;
    tick();
    cpl_ready_i = 1'b0;
    settle();
    chk("dup_single_cpl", cpl_valid_o, 0);
    chk("dup_err_sticky", err_o, 1);
    chk("dup_inflight", inflight_o, 6);

    // reset with IDs outstanding
    rst_ni = 1'b0;
    tick();
    chk("rst2_cmd_valid", cmd_valid_o, 0);
    chk("rst2_cpl_valid", cpl_valid_o, 0);
    chk("rst2_inflight", inflight_o, 0);
    chk("rst2_err", err_o, 0);
    chk("rst2_req_ready", req_ready_o, 0);
    rst_ni = 1'b1;
    set_req(1'b1, 1'b0, 64'hC0DE, 32'hC, 32'd4, 4'hC);
    tick();
    req_valid_i = 1'b0;
    settle();
    chk("rst2_new_id", cmd_id_o, 0);
    tick();
    resp(8'd3);
    chk("rst2_stale_err", err_o, 1);
    chk("rst2_stale_no_cpl", cpl_valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
